dft_sin_stall_collector: RTL
============================

# dft_sin_stall_collector

Issue and collect controller for the stall-able 5-stage single-precision sine pipeline in the DFT compute datapath. It accepts sine operands on a valid/ready handshake and drives them onto the pipeline's `a_sign/a_exp/a_man` inputs. It tracks in-flight operations with a valid shift register and captures the 37-bit fixed-point result `x` into a small output FIFO. It generates `astall` so that no result is ever lost when the downstream consumer back-pressures.

## Interface
Parameters:
- `LAT`, 5, pipeline register depth of the sine unit (enabled edges from operand to `x`)
- `XW`, 37, result width
- `DEPTH`, 4, output FIFO entries (power of two, ≥2)

Ports:
- `aclk` in 1: clock, shared with the sine unit
- `areset` in 1: reset; one clock, synchronous, active-high
- `in_valid` in 1: operand valid
- `in_ready` out 1: operand accepted when `in_valid && in_ready` at the rising edge
- `in_sign` in 1, `in_exp` in 8, `in_man` in 23: IEEE-754 operand fields
- `a_sign` out 1, `a_exp` out 8, `a_man` out 23: to the sine unit (combinational pass-through of `in_*`)
- `astall` out 1: pipeline stall to the sine unit; the unit advances only when `astall==0`
- `pipe_x` in XW: `x` output of the sine unit
- `out_valid` out 1, `out_ready` in 1, `out_x` out XW: result stream, FIFO head
- `busy` out 1: any operation in flight or buffered

## Operation
- `vld_sr[LAT-1:0]` shadows the pipeline. It shifts only when `astall==0`: `vld_sr[0] <= in_valid && in_ready`, `vld_sr[i] <= vld_sr[i-1]`. While `astall==1`, `vld_sr` holds.
- `vld_sr[LAT-1]==1` means `pipe_x` is a live result this cycle.
- `pop = out_valid && out_ready`; `full = (count==DEPTH)`.
- `astall = full && !pop`. It is combinational and has no register delay, because the sine unit's output register samples it in the same cycle.
- `in_ready = !astall`. Operands are never accepted while the pipeline is frozen.
- `push = vld_sr[LAT-1] && !astall`. It writes `pipe_x` into the FIFO tail. Bubbles (`vld_sr[LAT-1]==0`) are never written.
- FIFO: `wptr`/`rptr` are log2(DEPTH) bits and wrap modulo DEPTH. `count` is 0..DEPTH. Push and pop in the same cycle are legal, including when full, and leave `count` unchanged.
- `out_valid = (count!=0)`; `out_x = mem[rptr]`. Holding rule: `out_x` stays stable while `out_valid && !out_ready`.
- `busy = |vld_sr || (count!=0)`.
- Data is never reordered, duplicated or dropped. Results leave in operand acceptance order.

## Timing
- Reset state, applied at the edge where `areset==1`:
  - `vld_sr=0`, `wptr=rptr=0`, `count=0`
  - outputs: `out_valid=0`, `astall=0`, `in_ready=1`, `busy=0`
  - `out_x` is don't-care while `out_valid==0`.
- Reset mid-operation discards all in-flight and buffered results. The sine unit's internal registers are not reset; their contents are ignored because `vld_sr` is cleared.
- Latency with no stall: operand accepted at edge E; `pipe_x` is valid in the cycle after edge E+LAT-1; it is pushed at edge E+LAT; `out_valid` is seen after edge E+LAT.
- Each stalled cycle adds exactly one cycle to the latency of every in-flight operation.
- Throughput: one operation per cycle while `out_ready==1` continuously.
- The block never asserts `astall` while `count<DEPTH`. The block never asserts `astall` while a pop occurs.
- Simultaneous push and pop at `count==DEPTH`: `astall=0`, both occur, `count` stays DEPTH.

## Test plan
- **Single op after reset.** Apply one operand, 0.5 (`sign=0, exp=0x7E, man=0`), with `out_ready=1`.
  - `out_valid` pulses for one cycle exactly LAT+1 cycles after acceptance.
  - `out_x` equals the sine unit's result for 0.5.
  - `busy` falls the cycle after the pop.
- **Streaming.** Send 32 back-to-back operands with `out_ready=1`.
  - `astall` stays 0 and `in_ready` stays 1.
  - 32 results come out in order, one per cycle, compared against the golden model.
- **Back-pressure.** Set `out_ready=0` and send 10 operands.
  - `count` reaches 4, then `astall=1` and `in_ready=0`.
  - No results are lost: `vld_sr` freezes with 5 live entries and 1 operand is refused.
  - Then set `out_ready=1`. All 9 accepted results emerge in order and `astall` drops on the same cycle as the first pop.
- **Full with simultaneous pop.**
  - Hold `count==4` with `out_ready=1` and a live `pipe_x`: push and pop both occur, `count` stays 4, `astall==0`.
  - Make `out_ready` random (50%) over 200 operands. Check scoreboard order and that `out_x` holds stable while stalled.
- **Bubbles.** Drive `in_valid` in an alternating 1,0,1,0 pattern. Only the valid operations are pushed and no bubble appears on `out_valid`.
- **Reset mid-operation.** Assert `areset` for one cycle with 3 operations in flight and 2 buffered.
  - The next cycle shows `out_valid=0`, `busy=0`, `astall=0` and `in_ready=1`.
  - No stale result ever appears afterwards.

Source files
------------

// File: rtl/dft_sin_stall_collector_if.sv
// Operand/result bundle between the sine pipeline collector, the 5-stage sine unit and its producer/consumer.
interface dft_sin_stall_collector_if #(parameter int XW = 37);
  logic          in_valid, in_ready, in_sign;
  logic [7:0]    in_exp;
  logic [22:0]   in_man;
  logic          a_sign;
  logic [7:0]    a_exp;
  logic [22:0]   a_man;
  logic          astall;
  logic [XW-1:0] pipe_x;
  logic          out_valid, out_ready;
  logic [XW-1:0] out_x;
  logic          busy;

  modport master (
    input  in_valid, in_sign, in_exp, in_man, pipe_x, out_ready,
    output in_ready, a_sign, a_exp, a_man, astall, out_valid, out_x, busy
  );

  modport slave (
    output in_valid, in_sign, in_exp, in_man, pipe_x, out_ready,
    input  in_ready, a_sign, a_exp, a_man, astall, out_valid, out_x, busy
  );
endinterface

// File: rtl/dft_sin_stall_collector.sv
// Issue/collect controller for the stall-able sine pipeline: shadows in-flight ops with a valid
// shift register and stalls the unit only when the result FIFO is full and not draining.
module dft_sin_stall_collector #(
  parameter int LAT   = 5,
  parameter int XW    = 37,
  parameter int DEPTH = 4
) (
  input  logic                   aclk,
  input  logic                   areset,
  dft_sin_stall_collector_if.master bus
);
  localparam int          AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [LAT-1:0] vld_sr_q, vld_sr_d;
  logic [AW-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]    cnt_q, cnt_d;
  logic [XW-1:0]  mem_q [DEPTH];
  logic           full, pop, push, stall;

  always_comb begin
    full  = (cnt_q == FULL);
    pop   = (cnt_q != '0) && bus.out_ready;
    // Combinational: the unit's output register samples this in the same cycle.
    stall = full && !pop;
    push  = vld_sr_q[LAT-1] && !stall;

    vld_sr_d = vld_sr_q;
    if (!stall) begin
      vld_sr_d[0] = bus.in_valid;  // in_ready is 1 whenever we shift
      for (int i = 1; i < LAT; i++) vld_sr_d[i] = vld_sr_q[i-1];
    end

    wptr_d = push ? wptr_q + 1'b1 : wptr_q;
    rptr_d = pop  ? rptr_q + 1'b1 : rptr_q;
    cnt_d  = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      vld_sr_q <= '0;
      wptr_q   <= '0;
      rptr_q   <= '0;
      cnt_q    <= '0;
    end else begin
      vld_sr_q <= vld_sr_d;
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge aclk) begin
    if (push) mem_q[wptr_q] <= bus.pipe_x;
  end

  assign bus.a_sign    = bus.in_sign;
  assign bus.a_exp     = bus.in_exp;
  assign bus.a_man     = bus.in_man;
  assign bus.astall    = stall;
  assign bus.in_ready  = !stall;
  assign bus.out_valid = (cnt_q != '0);
  assign bus.out_x     = mem_q[rptr_q];
  assign bus.busy      = (|vld_sr_q) || (cnt_q != '0);
endmodule
